// File: rtl/bypass_ram_delay.sv
// Simple dual-port RAM with a pipelined read port and a sideband
// word/valid carried alongside the read, plus an optional output stage.

// Delay element: pass-through when ENABLE=0, one cleared register when ENABLE=1.
module bypass_ram_delay_reg #(
    parameter int DATA_WIDTH = 1,
    parameter int ENABLE     = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  out_valid_o
);

    if (ENABLE != 0) begin : g_reg
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        // Register data and valid; async clear drops anything in flight.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= in_data_i;
                valid_q <= in_valid_i;
            end
        end

        assign out_data_o  = data_q;
        assign out_valid_o = valid_q;
    end else begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_i;
        assign out_data_o     = in_data_i;
        assign out_valid_o    = in_valid_i;
    end

endmodule

// Top: RAM storage, stage A read register, optional stage B.
module bypass_ram_delay #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 1,
    parameter int BYPASS_WIDTH   = 1,
    parameter int OUT_REG_ENABLE = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   wr_data_i,
    input  logic                    wr_enable_i,
    input  logic [ADDR_WIDTH-1:0]   in_read_addr_i,
    input  logic [BYPASS_WIDTH-1:0] in_bypass_i,
    input  logic                    in_valid_i,
    output logic [DATA_WIDTH-1:0]   out_read_data_o,
    output logic [BYPASS_WIDTH-1:0] out_bypass_o,
    output logic                    out_valid_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int PW    = DATA_WIDTH + BYPASS_WIDTH;

    logic [DATA_WIDTH-1:0]   mem_q [DEPTH] = '{default: '0};

    logic [DATA_WIDTH-1:0]   data_a_d;
    logic [DATA_WIDTH-1:0]   data_a_q;
    logic [BYPASS_WIDTH-1:0] bypass_a_q;
    logic                    valid_a_q;
    logic [PW-1:0]           pack_b;

    // Write port; not reset so contents survive a pipeline flush.
    always_ff @(posedge clk_i) begin
        if (wr_enable_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read-first: the array is sampled before this edge's write lands.
    always_comb begin
        data_a_d = mem_q[in_read_addr_i];
    end

    // Stage A captures every cycle; valid is the only qualifier.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            data_a_q   <= '0;
            bypass_a_q <= '0;
            valid_a_q  <= 1'b0;
        end else begin
            data_a_q   <= data_a_d;
            bypass_a_q <= in_bypass_i;
            valid_a_q  <= in_valid_i;
        end
    end

    bypass_ram_delay_reg #(
        .DATA_WIDTH (PW),
        .ENABLE     (OUT_REG_ENABLE)
    ) u_out_reg (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_data_i   ({data_a_q, bypass_a_q}),
        .in_valid_i  (valid_a_q),
        .out_data_o  (pack_b),
        .out_valid_o (out_valid_o)
    );

    assign out_read_data_o = pack_b[PW-1:BYPASS_WIDTH];
    assign out_bypass_o    = pack_b[BYPASS_WIDTH-1:0];

endmodule

// File: tb/tb_bypass_ram_delay.sv
// Directed bench for bypass_ram_delay with and without the output
// register; a queue holds expected read results until the DUT returns them.

module tb_bypass_ram_delay;

    typedef struct packed {
        logic [15:0] data;
        logic        byp;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_en;
    logic [1:0]  rd_addr;
    logic        in_byp;
    logic        in_vld;

    logic [15:0] d0, d1;
    logic        b0, b1;
    logic        v0, v1;

    logic [15:0] mdl [4];
    exp_t        q0 [$];
    exp_t        q1 [$];
    logic        va, vb;
    int          n_chk;
    int          n_fail;

    bypass_ram_delay #(
        .DATA_WIDTH(16), .ADDR_WIDTH(2),
        .BYPASS_WIDTH(1), .OUT_REG_ENABLE(0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst_n),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_enable_i(wr_en),
        .in_read_addr_i(rd_addr), .in_bypass_i(in_byp),
        .in_valid_i(in_vld),
        .out_read_data_o(d0), .out_bypass_o(b0),
        .out_valid_o(v0)
    );

    bypass_ram_delay #(
        .DATA_WIDTH(16), .ADDR_WIDTH(2),
        .BYPASS_WIDTH(1), .OUT_REG_ENABLE(1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst_n),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .wr_enable_i(wr_en),
        .in_read_addr_i(rd_addr), .in_bypass_i(in_byp),
        .in_valid_i(in_vld),
        .out_read_data_o(d1), .out_bypass_o(b1),
        .out_valid_o(v1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero();
        chk("rst_v0", 32'(v0), 0);
        chk("rst_b0", 32'(b0), 0);
        chk("rst_d0", 32'(d0), 0);
        chk("rst_v1", 32'(v1), 0);
        chk("rst_b1", 32'(b1), 0);
        chk("rst_d1", 32'(d1), 0);
    endtask

    // One clock: drive inputs, record expectations, check outputs after the edge.
    task automatic step(input logic [1:0] ra, input logic byp,
                        input logic v, input logic we,
                        input logic [1:0] wa, input logic [15:0] wd);
        exp_t e;
        rd_addr = ra;
        in_byp  = byp;
        in_vld  = v;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        if (v) begin
            e.data = mdl[ra];
            e.byp  = byp;
            q0.push_back(e);
            q1.push_back(e);
        end
        @(posedge clk);
        if (we) mdl[wa] = wd;
        vb = va;
        va = v;
        #1;
        chk("valid0", 32'(v0), 32'(va));
        chk("valid1", 32'(v1), 32'(vb));
        if (v0) begin
            chk("q0_nonempty", 32'(q0.size() != 0), 1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                chk("data0", 32'(d0), 32'(e.data));
                chk("byp0", 32'(b0), 32'(e.byp));
            end
        end
        if (v1) begin
            chk("q1_nonempty", 32'(q1.size() != 0), 1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                chk("data1", 32'(d1), 32'(e.data));
                chk("byp1", 32'(b1), 32'(e.byp));
            end
        end
    endtask

    initial begin
        n_chk   = 0;
        n_fail  = 0;
        va      = 1'b0;
        vb      = 1'b0;
        for (int i = 0; i < 4; i++) mdl[i] = 16'h0;
        rst_n   = 1'b1;
        wr_addr = '0;
        wr_data = '0;
        wr_en   = 1'b0;
        rd_addr = '0;
        in_byp  = 1'b0;
        in_vld  = 1'b0;

        #1 rst_n = 1'b0;
        #1 chk_zero();
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Fill memory with valid low: outputs must stay invalid.
        step(2'd0, 1'b1, 1'b0, 1'b1, 2'd0, 16'h1111);
        step(2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 16'h2222);
        step(2'd2, 1'b1, 1'b0, 1'b1, 2'd2, 16'h3333);
        step(2'd3, 1'b1, 1'b0, 1'b1, 2'd3, 16'h4444);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);

        // Single reads: latency 1 on dut0, latency 2 on dut1.
        step(2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        chk("lat1_d0", 32'(d0), 32'h3333);
        chk("lat1_v1", 32'(v1), 0);
        step(2'd3, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        chk("lat2_d1", 32'(d1), 32'h3333);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        chk("lat2_d1b", 32'(d1), 32'h4444);
        chk("lat2_b1b", 32'(b1), 0);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);

        // Streaming with a bubble.
        step(2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        step(2'd1, 1'b1, 1'b0, 1'b0, 2'd0, 16'h0);
        step(2'd2, 1'b0, 1'b1, 1'b0, 2'd0, 16'h0);
        step(2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        chk("strm_d0", 32'(d0), 32'h4444);
        chk("strm_b0", 32'(b0), 1);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);

        // Read-during-write on the same address returns old data.
        step(2'd1, 1'b0, 1'b1, 1'b1, 2'd1, 16'hABCD);
        chk("rdw_old", 32'(d0), 32'h2222);
        step(2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        chk("rdw_new", 32'(d0), 32'hABCD);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);

        // Reset with requests in flight.
        step(2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        step(2'd2, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        step(2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        #2 rst_n = 1'b0;
        #1 chk_zero();
        q0.delete();
        q1.delete();
        va     = 1'b0;
        vb     = 1'b0;
        in_vld = 1'b0;
        @(posedge clk);
        #1 chk("rst_hold_v1", 32'(v1), 0);
        #2 rst_n = 1'b1;
        step(2'd1, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        chk("post_rst_d0", 32'(d0), 32'hABCD);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        chk("post_rst_d1", 32'(d1), 32'hABCD);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);

        // Writes alone never raise valid.
        step(2'd2, 1'b1, 1'b0, 1'b1, 2'd2, 16'h5A5A);
        step(2'd2, 1'b1, 1'b0, 1'b1, 2'd3, 16'hA5A5);
        step(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        step(2'd3, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);
        step(2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0);

        chk("q0_drain", 32'(q0.size()), 0);
        chk("q1_drain", 32'(q1.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bypass_ram_delay.md
Name: bypass_ram_delay

Overview:
- Simple dual-port RAM: one synchronous write port and one pipelined read port.
- Each read request carries a sideband bypass word and a valid bit, returned aligned with the read data.
- An optional extra output register stage is inserted for timing closure.
- Used as the node-storage stage of each quadtree lookup level: the address comes from the incoming key, and the bypass carries the in-flight pipeline context.

Parameters:
- DATA_WIDTH, 16: RAM word width in bits.
- ADDR_WIDTH, 1: RAM address width; depth is 2**ADDR_WIDTH words.
- BYPASS_WIDTH, 1: width of the sideband word delayed alongside the read.
- OUT_REG_ENABLE, 0: 0 gives read latency 1; 1 adds one register stage on data, bypass and valid (latency 2).

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- wr_addr_i  input  ADDR_WIDTH  write address.
- wr_data_i  input  DATA_WIDTH  write data.
- wr_enable_i  input  1  write strobe.
- in_read_addr_i  input  ADDR_WIDTH  read address.
- in_bypass_i  input  BYPASS_WIDTH  sideband word accompanying the read.
- in_valid_i  input  1  read request qualifier.
- out_read_data_o  output  DATA_WIDTH  read data.
- out_bypass_o  output  BYPASS_WIDTH  in_bypass_i, delayed to match the read data.
- out_valid_o  output  1  in_valid_i, delayed to match the read data.

Behaviour:
- Write path:
  - On a clock edge with wr_enable_i=1, mem[wr_addr_i] <= wr_data_i.
  - The write port operates independently of the read path and of in_valid_i.
- Read path, stage A:
  - Every clock edge registers mem[in_read_addr_i], in_bypass_i and in_valid_i, regardless of in_valid_i.
  - out_valid_o is the only qualifier for the outputs.
- Optional stage B (OUT_REG_ENABLE=1):
  - A second register stage on data, bypass and valid.
  - Latency is exactly 2 cycles for all three outputs.
- OUT_REG_ENABLE=0: stage A drives the outputs directly; latency is exactly 1 cycle.
- No backpressure:
  - One request is accepted per cycle; back-to-back valid requests return back-to-back.
  - Valid bubbles are preserved exactly.
- Read-during-write, same address, same edge: read-first, i.e. the read returns the old contents. New data is visible to a read issued on the following cycle or later.
- Reset (rst_i=0, asynchronous):
  - Clears all valid, bypass and read-data pipeline registers to 0 immediately.
  - out_valid_o=0 while reset is asserted and until the first registered valid after release.
  - Requests in flight when reset asserts are dropped.
- RAM contents:
  - Not affected by reset.
  - Power-up contents are 0 in simulation (initialise the array); treat as undefined in hardware.
  - Writes with wr_enable_i=1 during reset are not required to take effect.
- Width rules: addresses index the full 2**ADDR_WIDTH depth; no out-of-range case exists.
- Internal structure:
  - Implement the stage-B register as a reusable parameterised delay element with parameters DATA_WIDTH and ENABLE.
  - Ports: clk_i, rst_i, in_data_i, in_valid_i, out_data_o, out_valid_o.
  - ENABLE=0 is a combinational pass-through; ENABLE=1 is one register with async active-low clear.

Test Plan:
- Basic read, OUT_REG_ENABLE=0, DATA_WIDTH=16, ADDR_WIDTH=2: write 0x1111, 0x2222, 0x3333, 0x4444 to addresses 0-3, idle one cycle, then read address 2 with bypass=1, valid=1 -> exactly 1 cycle later out_read_data_o=0x3333, out_bypass_o=1, out_valid_o=1.
- Latency, OUT_REG_ENABLE=1, same contents: read address 3 with bypass=0 -> out_valid_o=1 exactly 2 cycles later with data 0x4444, bypass 0; out_valid_o=0 on cycle 1.
- Streaming: read addresses 0,1,2,3 on consecutive cycles with bypass 0,1,0,1 and valid pattern 1,0,1,1 -> outputs 0x1111,-,0x3333,0x4444 with the same valid pattern and bypass alignment, no gaps.
- Read-during-write: mem[1]=0x2222; on the same edge write 0xABCD to address 1 and read address 1 -> 0x2222; read again the next cycle -> 0xABCD.
- Reset mid-operation: issue 3 valid reads, assert rst_i=0 between clock edges -> out_valid_o, out_bypass_o and out_read_data_o go to 0 immediately (asynchronously). After release, the first new read returns the correct pre-reset RAM contents.
- Write isolation: write with in_valid_i=0 on all cycles -> out_valid_o stays 0 throughout.
